reg_file_dbg_access: RTL and testbench
======================================

// Module: reg_file_dbg_access
// PURPOSE
//  Debug-side initiator for the register file. Sits between a debug host and the register_file ports.
//  Accepts valid/ready commands (read, write, clear-all) only while the core is halted.
//  Drives the register file write port and read port 2; returns one response per command.
//  In all other cycles it passes the core's write port and rd_reg_2 through unchanged.
// PARAMETERS
//  DATA_WIDTH  32  register width
//  ADDR_WIDTH  5   register index width
//  NUM_REGS    32  registers in file; x0 is hardwired zero
// PORTS
//  clk           in   1           system clock
//  reset         in   1           synchronous, active-high reset
//  halted        in   1           core halted; gates command acceptance only
//  cmd_valid     in   1           command valid
//  cmd_ready     out  1           command accepted when valid&&ready at posedge
//  cmd_op        in   2           00 read, 01 write, 10 clear-all, 11 reserved
//  cmd_addr      in   ADDR_WIDTH  target register
//  cmd_data      in   DATA_WIDTH  write data
//  rsp_valid     out  1           response valid; held until rsp_ready
//  rsp_ready     in   1           host accepts response
//  rsp_data      out  DATA_WIDTH  read data / write data / clear count
//  rsp_err       out  1           error flag for this response
//  busy          out  1           debug owns register file ports (READ/WRITE/CLEAR/VERIFY)
//  core_wr_en    in   1           core write enable, pass-through
//  core_wr_reg   in   ADDR_WIDTH  core write index, pass-through
//  core_wr_data  in   DATA_WIDTH  core write data, pass-through
//  core_rd_reg_2 in   ADDR_WIDTH  core read index 2, pass-through
//  rf_wr_en      out  1           to register_file.wr_en
//  rf_wr_reg     out  ADDR_WIDTH  to register_file.wr_reg
//  rf_wr_data    out  DATA_WIDTH  to register_file.wr_data
//  rf_rd_reg_2   out  ADDR_WIDTH  to register_file.rd_reg_2
//  rf_rd_data_2  in   DATA_WIDTH  from register_file.rd_data_2 (combinational read)
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, clear counter=0, rf_* = core_* pass-through.
//  Reset mid-operation: IDLE at next edge; any pending response dropped; registers already cleared stay cleared.
//  cmd_ready = (state==IDLE) && halted. Command fields are registered on accept.
//  States:
//  - IDLE: on accept, go to READ, WRITE or CLEAR per op; reserved op goes to RESP (err=1, data=0).
//  - READ: rf_rd_reg_2=addr, rf_wr_en=0. Capture rf_rd_data_2 into rsp_data at edge. Go to RESP, err=0.
//  - WRITE: rf_wr_en=1, rf_wr_reg=addr, rf_wr_data=data. rsp_data=data. Go to RESP.
//    - addr==0: rf_wr_en stays 0, err=1.
//  - CLEAR: counter starts at 1; each cycle writes 0 to x[counter], then counter++.
//    - After writing x[NUM_REGS-1]: go to RESP, rsp_data=NUM_REGS-1, err=0. 31 write cycles at default.
//  - RESP: rsp_valid=1; rsp_data/rsp_err stable until rsp_ready at edge. Then go to IDLE, no bubble required.
//  Latency: accept edge N -> rsp_valid high after edge N+1 (read, write, reserved at N).
//  Port mux: only while busy, core_* inputs are ignored and the debug values are driven.
//  halted falling mid-operation does not abort; the operation and its response complete.
//  Read of x0 returns 0 (register file behaviour); no error.
//  Back-to-back: new command accepted the cycle after RESP handshake (state IDLE).
// CONFIGURATION
//  REG_FILE_DBG_READBACK_EN defined:
//  - WRITE to x1..x31 goes next to VERIFY (1 cycle).
//  - VERIFY: rf_rd_reg_2=addr; capture rf_rd_data_2 into rsp_data; err=1 if it differs from written data.
//  - Write latency: rsp_valid after edge N+2.
//  REG_FILE_DBG_READBACK_EN undefined: no VERIFY state; write response carries cmd_data, latency as above.
// TESTING
//  halted=1, write x5=0xDEADBEEF, then read x5 -> write rsp err=0; read rsp_data=0xDEADBEEF, err=0.
//  Write x0=0xFFFFFFFF -> rf_wr_en never high, rsp_err=1; read x0 -> rsp_data=0.
//  Write x1..x31 random, clear-all -> 31 cycles busy; rsp_data=31; every read returns 0.
//  halted=0 with cmd_valid=1 -> cmd_ready=0; core_wr_* visible on rf_* every cycle.
//  Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable; op=11 -> rsp_err=1, rsp_data=0.
//  Reset asserted mid-CLEAR at counter=10 -> IDLE next edge, rsp_valid=0, x11..x31 unchanged.

Source files
------------

// File: rtl/reg_file_dbg_access_if.sv
// Debug host command/response channel of reg_file_dbg_access.
// Valid/ready: a transfer happens on a posedge where valid && ready; the sender holds valid and payload stable until then.
interface reg_file_dbg_access_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/reg_file_dbg_access.sv
// Debug-side initiator for the register file: host read/write/clear-all commands while the core is halted.
// Optional macro REG_FILE_DBG_READBACK_EN adds a VERIFY read-back after every write to x1..x(NUM_REGS-1).
module reg_file_dbg_access #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  halted,
   reg_file_dbg_access_if.slave  dbg,
   output logic                  busy,
   output logic [2:0]            dbg_state,
   input  logic                  core_wr_en,
   input  logic [ADDR_WIDTH-1:0] core_wr_reg,
   input  logic [DATA_WIDTH-1:0] core_wr_data,
   input  logic [ADDR_WIDTH-1:0] core_rd_reg_2,
   output logic                  rf_wr_en,
   output logic [ADDR_WIDTH-1:0] rf_wr_reg,
   output logic [DATA_WIDTH-1:0] rf_wr_data,
   output logic [ADDR_WIDTH-1:0] rf_rd_reg_2,
   input  logic [DATA_WIDTH-1:0] rf_rd_data_2
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
      CLEAR = 3'd3,
      RESP  = 3'd4
`ifdef REG_FILE_DBG_READBACK_EN
      , VERIFY = 3'd5
`endif
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_REG    = ADDR_WIDTH'(NUM_REGS - 1);
   localparam logic [DATA_WIDTH-1:0] CLEAR_COUNT = DATA_WIDTH'(NUM_REGS - 1);

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [ADDR_WIDTH-1:0] clear_cnt;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  rsp_err_q;
   logic                  accept;

   assign dbg.cmd_ready = (state == IDLE) && halted;
   assign accept        = dbg.cmd_valid && dbg.cmd_ready;
   assign dbg.rsp_valid = (state == RESP);
   assign dbg.rsp_data  = rsp_data_q;
   assign dbg.rsp_err   = rsp_err_q;
   assign dbg_state     = state;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               case (dbg.cmd_op)
                  2'b00:   state_next = READ;
                  2'b01:   state_next = WRITE;
                  2'b10:   state_next = CLEAR;
                  default: state_next = RESP;
               endcase
            end
         end
         READ: state_next = RESP;
`ifdef REG_FILE_DBG_READBACK_EN
         WRITE:  state_next = (addr_q != '0) ? VERIFY : RESP;
         VERIFY: state_next = RESP;
`else
         WRITE: state_next = RESP;
`endif
         CLEAR: if (clear_cnt == LAST_REG) state_next = RESP;
         RESP:  if (dbg.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == READ) || (state == WRITE) || (state == CLEAR)
`ifdef REG_FILE_DBG_READBACK_EN
             || (state == VERIFY)
`endif
             ;
   end

   // Core ports pass straight through unless a debug operation owns the register file.
   always_comb begin
      rf_wr_en    = core_wr_en;
      rf_wr_reg   = core_wr_reg;
      rf_wr_data  = core_wr_data;
      rf_rd_reg_2 = core_rd_reg_2;
      if (busy) begin
         rf_wr_en    = 1'b0;
         rf_wr_reg   = addr_q;
         rf_wr_data  = data_q;
         rf_rd_reg_2 = addr_q;
         if (state == WRITE) begin
            rf_wr_en = (addr_q != '0);
         end else if (state == CLEAR) begin
            rf_wr_en   = 1'b1;
            rf_wr_reg  = clear_cnt;
            rf_wr_data = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q     <= '0;
         data_q     <= '0;
         clear_cnt  <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q    <= dbg.cmd_addr;
                  data_q    <= dbg.cmd_data;
                  clear_cnt <= ADDR_WIDTH'(1);
                  if (dbg.cmd_op == 2'b11) begin
                     rsp_data_q <= '0;
                     rsp_err_q  <= 1'b1;
                  end
               end
            end
            READ: begin
               rsp_data_q <= rf_rd_data_2;
               rsp_err_q  <= 1'b0;
            end
            WRITE: begin
               rsp_data_q <= data_q;
               rsp_err_q  <= (addr_q == '0);
            end
`ifdef REG_FILE_DBG_READBACK_EN
            VERIFY: begin
               rsp_data_q <= rf_rd_data_2;
               rsp_err_q  <= (rf_rd_data_2 != data_q);
            end
`endif
            CLEAR: begin
               clear_cnt <= clear_cnt + 1'b1;
               if (clear_cnt == LAST_REG) begin
                  rsp_data_q <= CLEAR_COUNT;
                  rsp_err_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_reg_file_dbg_access.sv
// Bench for reg_file_dbg_access: behavioural register file plus a register-content reference model.
// Build with REG_FILE_DBG_READBACK_EN defined to expect the longer write latency.
module tb_reg_file_dbg_access;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;
`ifdef REG_FILE_DBG_READBACK_EN
   localparam int WR_LAT = 2;
`else
   localparam int WR_LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          halted;
   logic          busy;
   logic [2:0]    dbg_state;
   logic          core_wr_en;
   logic [AW-1:0] core_wr_reg;
   logic [DW-1:0] core_wr_data;
   logic [AW-1:0] core_rd_reg_2;
   logic          rf_wr_en;
   logic [AW-1:0] rf_wr_reg;
   logic [DW-1:0] rf_wr_data;
   logic [AW-1:0] rf_rd_reg_2;
   logic [DW-1:0] rf_rd_data_2;

   int checks   = 0;
   int failures = 0;
   logic drop_halt = 1'b0;

   logic [DW-1:0] ref_regs [NR];
   logic [DW-1:0] rf_mem   [NR];

   reg_file_dbg_access_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dbg ();

   reg_file_dbg_access #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
      .clk           (clk),
      .reset         (reset),
      .halted        (halted),
      .dbg           (dbg),
      .busy          (busy),
      .dbg_state     (dbg_state),
      .core_wr_en    (core_wr_en),
      .core_wr_reg   (core_wr_reg),
      .core_wr_data  (core_wr_data),
      .core_rd_reg_2 (core_rd_reg_2),
      .rf_wr_en      (rf_wr_en),
      .rf_wr_reg     (rf_wr_reg),
      .rf_wr_data    (rf_wr_data),
      .rf_rd_reg_2   (rf_rd_reg_2),
      .rf_rd_data_2  (rf_rd_data_2)
   );

   // clock
   always #5 clk = ~clk;

   // register file the DUT drives: x0 reads zero, writes to x0 ignored
   always @(posedge clk) begin
      if (rf_wr_en && rf_wr_reg != '0) rf_mem[rf_wr_reg] <= rf_wr_data;
   end
   assign rf_rd_data_2 = (rf_rd_reg_2 == '0) ? '0 : rf_mem[rf_rd_reg_2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // issues one command and completes its response handshake; caller is 2 time units after a posedge
   task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int hold, output logic [DW-1:0] rdata, output logic rerr,
                           output int lat, output int busy_n, output logic wr_seen);
      int n = 0;
      lat = 0; busy_n = 0; wr_seen = 1'b0;
      dbg.cmd_valid = 1'b1; dbg.cmd_op = op; dbg.cmd_addr = addr; dbg.cmd_data = data;
      dbg.rsp_ready = 1'b0;
      #1;
      while (!dbg.cmd_ready && n < 50) begin @(posedge clk); #2; n++; end
      check("accept_wait", n, 0);
      @(posedge clk); #2;
      dbg.cmd_valid = 1'b0;
      if (drop_halt) halted = 1'b0;
      while (!dbg.rsp_valid && lat < 100) begin
         if (busy) busy_n++;
         if (rf_wr_en) wr_seen = 1'b1;
         @(posedge clk); #2;
         lat++;
      end
      check("rsp_timeout", lat < 100, 1);
      rdata = dbg.rsp_data;
      rerr  = dbg.rsp_err;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #2;
         check("hold_valid", dbg.rsp_valid, 1);
         check("hold_payload", {dbg.rsp_err, dbg.rsp_data}, {rerr, rdata});
      end
      dbg.rsp_ready = 1'b1;
      @(posedge clk); #2;
      dbg.rsp_ready = 1'b0;
      check("rsp_released", dbg.rsp_valid, 0);
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int hold);
      logic [DW-1:0] d; logic e, w; int lat, bn;
      send_cmd(2'b01, addr, data, hold, d, e, lat, bn, w);
      check("wr_lat", lat, (addr == 0) ? 1 : WR_LAT);
      check("wr_data", d, data);
      check("wr_err", e, addr == 0);
      check("wr_en_seen", w, addr != 0);
      if (addr != 0) ref_regs[addr] = data;
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input int hold);
      logic [DW-1:0] d; logic e, w; int lat, bn;
      send_cmd(2'b00, addr, '0, hold, d, e, lat, bn, w);
      check("rd_lat", lat, 1);
      check("rd_data", d, (addr == 0) ? '0 : ref_regs[addr]);
      check("rd_err", e, 0);
      check("rd_no_write", w, 0);
   endtask

   initial begin
      logic [DW-1:0] d; logic e, w; int lat, bn;
      reset = 1'b1; halted = 1'b0;
      dbg.cmd_valid = 1'b0; dbg.cmd_op = '0; dbg.cmd_addr = '0; dbg.cmd_data = '0; dbg.rsp_ready = 1'b0;
      core_wr_en = 1'b0; core_wr_reg = '0; core_wr_data = '0; core_rd_reg_2 = '0;
      for (int i = 0; i < NR; i++) ref_regs[i] = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_rsp_valid", dbg.rsp_valid, 0);
      check("rst_rsp_data", dbg.rsp_data, 0);
      check("rst_rsp_err", dbg.rsp_err, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;

      // not halted: commands refused, core traffic fills the register file
      for (int i = 1; i < NR; i++) begin
         core_wr_en = 1'b1; core_wr_reg = AW'(i); core_wr_data = $urandom;
         core_rd_reg_2 = AW'($urandom_range(0, NR - 1));
         dbg.cmd_valid = 1'b1; dbg.cmd_op = 2'b01;
         #1;
         check("not_halted_ready", dbg.cmd_ready, 0);
         check("pass_through", {rf_wr_en, rf_wr_reg, rf_wr_data, rf_rd_reg_2},
               {core_wr_en, core_wr_reg, core_wr_data, core_rd_reg_2});
         ref_regs[i] = core_wr_data;
         @(posedge clk); #2;
      end
      core_wr_en = 1'b0; dbg.cmd_valid = 1'b0;
      check("not_halted_no_rsp", dbg.rsp_valid, 0);

      halted = 1'b1;
      do_write(5'd5, 32'hDEADBEEF, 0);
      do_read(5'd5, 0);
      do_write(5'd0, 32'hFFFFFFFF, 0);
      do_read(5'd0, 0);

      repeat (24) begin
         if ($urandom_range(0, 1) == 1) do_write(AW'($urandom_range(0, NR - 1)), $urandom, $urandom_range(0, 3));
         else do_read(AW'($urandom_range(0, NR - 1)), $urandom_range(0, 3));
      end

      do_read(AW'($urandom_range(1, NR - 1)), 5);

      send_cmd(2'b11, AW'($urandom_range(0, NR - 1)), $urandom, 2, d, e, lat, bn, w);
      check("rsv_lat", lat, 0);
      check("rsv_data", d, 0);
      check("rsv_err", e, 1);

      // halted dropping after acceptance must not abort the write
      drop_halt = 1'b1;
      do_write(5'd7, $urandom, 0);
      drop_halt = 1'b0;
      halted = 1'b1;
      do_read(5'd7, 0);

      send_cmd(2'b10, '0, '0, 0, d, e, lat, bn, w);
      check("clr_lat", lat, NR - 1);
      check("clr_busy", bn, NR - 1);
      check("clr_data", d, NR - 1);
      check("clr_err", e, 0);
      for (int i = 1; i < NR; i++) ref_regs[i] = '0;
      for (int a = 0; a < NR; a++) do_read(AW'(a), 0);

      // reset while the clear counter sits at 10
      for (int i = 1; i < NR; i++) do_write(AW'(i), $urandom, 0);
      dbg.cmd_valid = 1'b1; dbg.cmd_op = 2'b10;
      #1;
      check("clr2_ready", dbg.cmd_ready, 1);
      @(posedge clk); #2;
      dbg.cmd_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      check("clr2_busy", busy, 1);
      reset = 1'b1;
      @(posedge clk); #2;
      check("midrst_rsp_valid", dbg.rsp_valid, 0);
      check("midrst_busy", busy, 0);
      reset = 1'b0;
      #1;
      check("midrst_idle_ready", dbg.cmd_ready, 1);
      for (int i = 1; i <= 10; i++) ref_regs[i] = '0;
      @(posedge clk); #2;
      for (int a = 0; a < NR; a++) do_read(AW'(a), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
